// File: rtl/instr_mem_pipelined.sv
// instr_mem_pipelined
//   Cell-addressed instruction memory with a registered, one-cycle fetch.
//   An instruction is CPW = WORD_LEN/CELL_SIZE consecutive cells, with the
//   lowest address holding the most-significant cell; addresses wrap modulo
//   MEM_SIZE. After reset the whole array is cleared one word per cycle
//   (INIT) before fetches and program writes are honoured (RUN).
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   fetch_req/addr      fetch request and cell address (PC)
//   fetch_ready         request accepted this cycle when high
//   stall               downstream hold while instr_valid is high
//   instr_valid         instruction / instr_pc / flags valid
//   instruction         fetched word (0 for out-of-range addresses)
//   instr_pc            address of the delivered word
//   misaligned          delivered address not a multiple of CPW
//   out_of_range        delivered address >= MEM_SIZE
//   prog_we/addr/data   program-load write port (wins over a fetch)
//   init_done           clearing complete
//   parity_err          only with INSTR_MEM_PARITY_EN: a fetched cell failed
//                       its even-parity check
//
// Optional feature macro: INSTR_MEM_PARITY_EN (per-cell parity storage).
module instr_mem_pipelined #(
  parameter int WORD_LEN  = 32,
  parameter int CELL_SIZE = 4,
  parameter int MEM_SIZE  = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_req,
  input  logic [WORD_LEN-1:0] fetch_addr,
  output logic                fetch_ready,
  input  logic                stall,
  output logic                instr_valid,
  output logic [WORD_LEN-1:0] instruction,
  output logic [WORD_LEN-1:0] instr_pc,
  output logic                misaligned,
  output logic                out_of_range,
  input  logic                prog_we,
  input  logic [WORD_LEN-1:0] prog_addr,
  input  logic [WORD_LEN-1:0] prog_data,
`ifdef INSTR_MEM_PARITY_EN
  output logic                parity_err,
`endif
  output logic                init_done
);

  localparam int CPW    = WORD_LEN / CELL_SIZE;
  localparam int AW     = $clog2(MEM_SIZE);
  localparam int NWORDS = MEM_SIZE / CPW;
  localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [CELL_SIZE-1:0] mem_q [MEM_SIZE];

  logic [0:0]          state_q, state_d;
  logic [CW-1:0]       init_cnt_q, init_cnt_d;
  logic                init_done_q, init_done_d;
  logic                instr_valid_q, instr_valid_d;
  logic [WORD_LEN-1:0] instruction_q, instruction_d;
  logic [WORD_LEN-1:0] instr_pc_q, instr_pc_d;
  logic                misaligned_q, misaligned_d;
  logic                out_of_range_q, out_of_range_d;

  logic                fetch_oor_s, fetch_mis_s, prog_oor_s;
  logic                fetch_ready_s, accept_s, hold_s;
  logic [WORD_LEN-1:0] rd_word_s;
  logic                mem_we_s;
  logic [AW-1:0]       mem_waddr_s, init_addr_s;
  logic [WORD_LEN-1:0] mem_wdata_s;

`ifdef INSTR_MEM_PARITY_EN
  logic par_q [MEM_SIZE];
  logic parity_err_q, parity_err_d;
  logic rd_perr_s;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic cell_par(input logic [CELL_SIZE-1:0] cell);
    return ^cell;
  endfunction
`endif

  // Address classification, read mux and handshake.
  always_comb begin
    // Any bit at or above log2(MEM_SIZE) puts the address outside the array.
    fetch_oor_s   = |(fetch_addr >> AW);
    prog_oor_s    = |(prog_addr >> AW);
    fetch_mis_s   = (fetch_addr % WORD_LEN'(CPW)) != '0;
    hold_s        = instr_valid_q && stall;
    fetch_ready_s = (state_q == ST_RUN) && !prog_we && !hold_s;
    accept_s      = fetch_req && fetch_ready_s;
    rd_word_s     = '0;
    for (int i = 0; i < CPW; i++) begin
      rd_word_s[WORD_LEN-1-i*CELL_SIZE -: CELL_SIZE] = mem_q[fetch_addr[AW-1:0] + AW'(i)];
    end
`ifdef INSTR_MEM_PARITY_EN
    rd_perr_s = 1'b0;
    for (int i = 0; i < CPW; i++) begin
      rd_perr_s = rd_perr_s |
                  (cell_par(mem_q[fetch_addr[AW-1:0] + AW'(i)]) ^ par_q[fetch_addr[AW-1:0] + AW'(i)]);
    end
`endif
  end

  // Write port selection: clearing during INIT, program load during RUN.
  always_comb begin
    init_addr_s = AW'(int'(init_cnt_q) * CPW);
    if (state_q == ST_INIT) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = init_addr_s;
      mem_wdata_s = '0;
    end else begin
      mem_we_s    = prog_we && !prog_oor_s;
      mem_waddr_s = prog_addr[AW-1:0];
      mem_wdata_s = prog_data;
    end
  end

  // Next-state logic for the clearing FSM and the registered fetch outputs.
  always_comb begin
    state_d        = state_q;
    init_cnt_d     = init_cnt_q;
    init_done_d    = init_done_q;
    instr_valid_d  = instr_valid_q;
    instruction_d  = instruction_q;
    instr_pc_d     = instr_pc_q;
    misaligned_d   = misaligned_q;
    out_of_range_d = out_of_range_q;
`ifdef INSTR_MEM_PARITY_EN
    parity_err_d   = parity_err_q;
`endif
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + CW'(1);
        if (init_cnt_q == CW'(NWORDS - 1)) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end else begin
          state_d     = ST_INIT;
        end
      end
      ST_RUN: begin
        if (hold_s) begin
          instr_valid_d = 1'b1;
        end else if (accept_s) begin
          instr_valid_d  = 1'b1;
          instruction_d  = fetch_oor_s ? '0 : rd_word_s;
          instr_pc_d     = fetch_addr;
          misaligned_d   = fetch_mis_s;
          out_of_range_d = fetch_oor_s;
`ifdef INSTR_MEM_PARITY_EN
          parity_err_d   = fetch_oor_s ? 1'b0 : rd_perr_s;
`endif
        end else begin
          // Payload and flags keep their last values; only valid drops.
          instr_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Control and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_INIT;
      init_cnt_q     <= '0;
      init_done_q    <= 1'b0;
      instr_valid_q  <= 1'b0;
      instruction_q  <= '0;
      instr_pc_q     <= '0;
      misaligned_q   <= 1'b0;
      out_of_range_q <= 1'b0;
`ifdef INSTR_MEM_PARITY_EN
      parity_err_q   <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      init_cnt_q     <= init_cnt_d;
      init_done_q    <= init_done_d;
      instr_valid_q  <= instr_valid_d;
      instruction_q  <= instruction_d;
      instr_pc_q     <= instr_pc_d;
      misaligned_q   <= misaligned_d;
      out_of_range_q <= out_of_range_d;
`ifdef INSTR_MEM_PARITY_EN
      parity_err_q   <= parity_err_d;
`endif
    end
  end

  // Storage array: one word (CPW cells, MS cell first) written per cycle.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < CPW; i++) begin
        mem_q[mem_waddr_s + AW'(i)] <= mem_wdata_s[WORD_LEN-1-i*CELL_SIZE -: CELL_SIZE];
`ifdef INSTR_MEM_PARITY_EN
        par_q[mem_waddr_s + AW'(i)] <= cell_par(mem_wdata_s[WORD_LEN-1-i*CELL_SIZE -: CELL_SIZE]);
`endif
      end
    end
  end

  assign fetch_ready  = fetch_ready_s;
  assign instr_valid  = instr_valid_q;
  assign instruction  = instruction_q;
  assign instr_pc     = instr_pc_q;
  assign misaligned   = misaligned_q;
  assign out_of_range = out_of_range_q;
  assign init_done    = init_done_q;
`ifdef INSTR_MEM_PARITY_EN
  assign parity_err   = parity_err_q;
`endif

endmodule
